// File: rtl/calc_exec_ctrl_pkg.sv
// Shared codes for the calculator sequencer: broadcast state codes, opcodes,
// key types, error codes and the internal FSM encoding.
package calc_exec_ctrl_pkg;

  // Broadcast state codes seen by the arithmetic units
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTA  = 3'd1;
  localparam logic [2:0] ST_ENTB  = 3'd2;
  localparam logic [2:0] ST_EXECB = 3'd3;
  localparam logic [2:0] ST_SHOW  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  // Opcodes
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_POW = 4'd4;

  // Key types and the sign-toggle digit code
  localparam logic [1:0] KEY_DIGIT = 2'd0;
  localparam logic [1:0] KEY_OP    = 2'd1;
  localparam logic [1:0] KEY_EQ    = 2'd2;
  localparam logic [1:0] KEY_CLR   = 2'd3;
  localparam logic [3:0] KEY_NEG   = 4'd10;

  // Error codes
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNIT  = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_CHAIN = 2'd3;

  typedef enum logic [2:0] {
    FsmIdle, FsmEntA, FsmEntB, FsmArm, FsmExec, FsmShow, FsmErr
  } fsm_e;

  // ARM is reported as ENTB: operands are still frozen, execution not yet started
  function automatic logic [2:0] state_code(input fsm_e s);
    case (s)
      FsmEntA: return ST_ENTA;
      FsmEntB: return ST_ENTB;
      FsmArm:  return ST_ENTB;
      FsmExec: return ST_EXECB;
      FsmShow: return ST_SHOW;
      FsmErr:  return ST_ERR;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/calc_exec_ctrl_digit_accum.sv
// Combinational operand entry step: appends a decimal digit (away from zero)
// or toggles the sign. ovf_o flags a key that must be dropped.
module calc_digit_accum
  import calc_exec_ctrl_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] cur_i,
  input  logic [3:0]   key_i,
  output logic [N-1:0] nxt_o,
  output logic         ovf_o
);

  logic [N+4:0] cur_w;
  logic [N+4:0] dig_w;
  logic [N+4:0] wide;

  // Compute cur*10 +/- d with 5 guard bits, then range-check back to N bits
  always_comb begin
    cur_w = {{5{cur_i[N-1]}}, cur_i};
    dig_w = {{(N+1){1'b0}}, key_i};
    if (cur_i[N-1]) begin
      wide = (cur_w << 3) + (cur_w << 1) - dig_w;
    end else begin
      wide = (cur_w << 3) + (cur_w << 1) + dig_w;
    end
    nxt_o = wide[N-1:0];
    ovf_o = (wide[N+4:N-1] != {6{wide[N-1]}});
    if (key_i == KEY_NEG) begin
      nxt_o = -cur_i;
      ovf_o = (cur_i == {1'b1, {(N-1){1'b0}}});
    end else if (key_i > 4'd9) begin
      nxt_o = cur_i;
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/calc_exec_ctrl.sv
// Calculator top-level sequencer: keypad entry, unit arm/execute with watchdog,
// result/error latching and result chaining.
module calc_exec_ctrl
  import calc_exec_ctrl_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned M       = 24,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         key_valid,
  input  logic [1:0]   key_type,
  input  logic [3:0]   key_data,
  input  logic         unit_done,
  input  logic         unit_error,
  input  logic [M-1:0] unit_result,
  output logic [2:0]   state,
  output logic [3:0]   opcode,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         unit_clr,
  output logic         busy,
  output logic [M-1:0] result,
  output logic         result_valid,
  output logic         err_flag,
  output logic [1:0]   err_code
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  fsm_e           fsm_q, fsm_d;
  logic [2:0]     state_q, state_d;
  logic [3:0]     opcode_q, opcode_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [M-1:0]   result_q, result_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           unit_clr_q, unit_clr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   acc_cur, acc_nxt;
  logic           acc_ovf;
  logic           key_dig, key_op, key_eq, key_clr;
  logic           res_fits;

  // Fresh entries (IDLE, SHOW) start from zero; otherwise extend the live operand
  assign acc_cur = (fsm_q == FsmEntA) ? a_q : ((fsm_q == FsmEntB) ? b_q : '0);

  calc_digit_accum #(.N(N)) u_accum (
    .cur_i (acc_cur),
    .key_i (key_data),
    .nxt_o (acc_nxt),
    .ovf_o (acc_ovf)
  );

  // Next-state, operand and error logic
  always_comb begin
    fsm_d      = fsm_q;
    opcode_d   = opcode_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    unit_clr_d = 1'b0;

    key_dig  = key_valid && (key_type == KEY_DIGIT) && !acc_ovf;
    key_op   = key_valid && (key_type == KEY_OP);
    key_eq   = key_valid && (key_type == KEY_EQ);
    key_clr  = key_valid && (key_type == KEY_CLR);
    res_fits = (result_q[M-1:N-1] == {(M-N+1){result_q[N-1]}});

    if (key_clr) begin
      fsm_d      = FsmIdle;
      opcode_d   = '0;
      a_d        = '0;
      b_d        = '0;
      result_d   = '0;
      err_code_d = ERR_NONE;
      cnt_d      = '0;
      // Abort mid-operation: the unit must be cleared as well
      unit_clr_d = (fsm_q == FsmArm) || (fsm_q == FsmExec);
    end else begin
      case (fsm_q)
        FsmIdle: begin
          if (key_dig) begin
            a_d   = acc_nxt;
            fsm_d = FsmEntA;
          end else if (key_op) begin
            opcode_d = key_data;
            a_d      = '0;
            b_d      = '0;
            fsm_d    = FsmEntB;
          end
        end
        FsmEntA: begin
          if (key_dig) begin
            a_d = acc_nxt;
          end else if (key_op) begin
            opcode_d = key_data;
            b_d      = '0;
            fsm_d    = FsmEntB;
          end
        end
        FsmEntB: begin
          if (key_dig) begin
            b_d = acc_nxt;
          end else if (key_op) begin
            opcode_d = key_data;
          end else if (key_eq) begin
            unit_clr_d = 1'b1;
            fsm_d      = FsmArm;
          end
        end
        FsmArm: begin
          cnt_d = '0;
          fsm_d = FsmExec;
        end
        FsmExec: begin
          // A done in the timeout cycle still counts as success
          if (unit_done) begin
            if (unit_error) begin
              err_code_d = ERR_UNIT;
              fsm_d      = FsmErr;
            end else begin
              result_d = unit_result;
              fsm_d    = FsmShow;
            end
          end else if (cnt_q == CW'(TMO_CYC - 1)) begin
            err_code_d = ERR_TMO;
            unit_clr_d = 1'b1;
            fsm_d      = FsmErr;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FsmShow: begin
          if (key_dig) begin
            a_d   = acc_nxt;
            fsm_d = FsmEntA;
          end else if (key_op || key_eq) begin
            if (!res_fits) begin
              err_code_d = ERR_CHAIN;
              fsm_d      = FsmErr;
            end else if (key_op) begin
              a_d      = result_q[N-1:0];
              opcode_d = key_data;
              b_d      = '0;
              fsm_d    = FsmEntB;
            end else begin
              a_d        = result_q[N-1:0];
              unit_clr_d = 1'b1;
              fsm_d      = FsmArm;
            end
          end
        end
        FsmErr: ;
        default: fsm_d = FsmIdle;
      endcase
    end

    state_d = state_code(fsm_d);
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q      <= FsmIdle;
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      err_code_q <= ERR_NONE;
      unit_clr_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
      unit_clr_q <= unit_clr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign state        = state_q;
  assign opcode       = opcode_q;
  assign a            = a_q;
  assign b            = b_q;
  assign result       = result_q;
  assign err_code     = err_code_q;
  assign unit_clr     = unit_clr_q;
  assign busy         = (fsm_q == FsmArm) || (fsm_q == FsmExec);
  assign result_valid = (fsm_q == FsmShow);
  assign err_flag     = (fsm_q == FsmErr);

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Self-checking bench for calc_exec_ctrl against a behavioural keypad model.
module tb_calc_exec_ctrl;
  import calc_exec_ctrl_pkg::*;

  localparam int TMO = 64;
  localparam int K_DIG = 0, K_OP = 1, K_EQ = 2, K_CLR = 3;
  localparam int MI = 0, MA = 1, MB = 2, MARM = 3, MEX = 4, MSH = 5, MER = 6;

  logic        CLK, RST, key_valid, unit_done, unit_error;
  logic [1:0]  key_type;
  logic [3:0]  key_data;
  logic [23:0] unit_result;
  logic [2:0]  state;
  logic [3:0]  opcode;
  logic [15:0] a, b;
  logic        unit_clr, busy, result_valid, err_flag;
  logic [23:0] result;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  int m_mode, m_a, m_b, m_op, m_res, m_err;
  bit m_clr;

  calc_exec_ctrl #(.N(16), .M(24), .TMO_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .key_valid(key_valid), .key_type(key_type),
    .key_data(key_data), .unit_done(unit_done), .unit_error(unit_error),
    .unit_result(unit_result), .state(state), .opcode(opcode), .a(a), .b(b),
    .unit_clr(unit_clr), .busy(busy), .result(result), .result_valid(result_valid),
    .err_flag(err_flag), .err_code(err_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit fits16(input int v);
    return (v >= -32768) && (v <= 32767);
  endfunction

  function automatic logic [2:0] exp_state(input int md);
    case (md)
      MA:       return ST_ENTA;
      MB, MARM: return ST_ENTB;
      MEX:      return ST_EXECB;
      MSH:      return ST_SHOW;
      MER:      return ST_ERR;
      default:  return ST_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MI; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0; m_clr = 0;
  endtask

  task automatic entry(input int cur, input int d, output int n, output bit ok);
    n = cur;
    if (d == 10) begin
      n = -cur; ok = (cur != -32768);
    end else if (d > 9) begin
      ok = 0;
    end else begin
      n = (cur >= 0) ? cur * 10 + d : cur * 10 - d;
      ok = fits16(n);
    end
  endtask

  task automatic model_key(input int t, input int d);
    int n; bit ok;
    m_clr = 0;
    if (t == K_CLR) begin
      m_clr = (m_mode == MARM) || (m_mode == MEX);
      m_mode = MI; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0;
      return;
    end
    if (m_mode == MARM || m_mode == MEX || m_mode == MER) return;
    if (t == K_DIG) begin
      entry((m_mode == MB) ? m_b : ((m_mode == MA) ? m_a : 0), d, n, ok);
      if (ok) begin
        if (m_mode == MB) m_b = n;
        else begin m_a = n; m_mode = MA; end
      end
    end else if (t == K_OP) begin
      case (m_mode)
        MI: begin m_op = d; m_a = 0; m_b = 0; m_mode = MB; end
        MA: begin m_op = d; m_b = 0; m_mode = MB; end
        MB: m_op = d;
        MSH: if (fits16(m_res)) begin m_a = m_res; m_op = d; m_b = 0; m_mode = MB; end
             else begin m_err = 3; m_mode = MER; end
        default: ;
      endcase
    end else begin
      if (m_mode == MB) begin m_mode = MARM; m_clr = 1; end
      else if (m_mode == MSH) begin
        if (fits16(m_res)) begin m_a = m_res; m_mode = MARM; m_clr = 1; end
        else begin m_err = 3; m_mode = MER; end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":state"}, 32'(state), 32'(exp_state(m_mode)));
    chk({tag, ":a"}, 32'(a), 32'(m_a[15:0]));
    chk({tag, ":b"}, 32'(b), 32'(m_b[15:0]));
    chk({tag, ":opcode"}, 32'(opcode), 32'(m_op[3:0]));
    chk({tag, ":result"}, 32'(result), 32'(m_res[23:0]));
    chk({tag, ":err_code"}, 32'(err_code), 32'(m_err[1:0]));
    chk({tag, ":result_valid"}, 32'(result_valid), 32'(m_mode == MSH));
    chk({tag, ":err_flag"}, 32'(err_flag), 32'(m_mode == MER));
    chk({tag, ":busy"}, 32'(busy), 32'(m_mode == MARM || m_mode == MEX));
    chk({tag, ":unit_clr"}, 32'(unit_clr), 32'(m_clr));
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic press(input int t, input int d);
    key_valid = 1'b1; key_type = t[1:0]; key_data = d[3:0];
    tick();
    key_valid = 1'b0;
    model_key(t, d);
    check_model($sformatf("key%0d_%0d", t, d));
  endtask

  // Called in ARM; lat=0 means the unit never finishes
  task automatic run_exec(input int lat, input bit err, input logic [23:0] res);
    int n, clrs, exp_n;
    bit done_ok;
    n = 0; clrs = 0;
    tick();
    while (state === ST_EXECB && n < 200) begin
      n++;
      if (unit_clr) clrs++;
      unit_done = (n == lat); unit_error = err; unit_result = res;
      tick();
      unit_done = 1'b0; unit_error = 1'b0;
    end
    done_ok = (lat >= 1) && (lat <= TMO);
    exp_n = done_ok ? lat : TMO;
    m_clr = 0;
    if (done_ok && !err) begin m_res = int'($signed(res)); m_mode = MSH; end
    else if (done_ok) begin m_err = 1; m_mode = MER; end
    else begin m_err = 2; m_mode = MER; m_clr = 1; end
    chk("exec_len", 32'(n), 32'(exp_n));
    chk("clr_in_exec", 32'(clrs), 32'd0);
    check_model("exec_end");
  endtask

  initial begin
    RST = 1'b1; key_valid = 1'b0; key_type = 2'd0; key_data = 4'd0;
    unit_done = 1'b0; unit_error = 1'b0; unit_result = '0;
    #3;
    model_reset();
    check_model("reset");
    @(negedge CLK); RST = 1'b0;
    tick();

    // 2 POW 3 = 8 after 40 execute cycles
    press(K_DIG, 2); press(K_OP, int'(OP_POW)); press(K_DIG, 3); press(K_EQ, 0);
    run_exec(40, 1'b0, 24'd8);
    chk("pow_result", 32'(result), 32'd8);
    // Chain 8 POW 2 = 64
    press(K_OP, int'(OP_POW)); press(K_DIG, 2);
    chk("chain_a", 32'(a), 32'd8);
    press(K_EQ, 0);
    run_exec(7, 1'b0, 24'd64);
    // Re-execute; done lands on the timeout cycle and must win
    press(K_EQ, 0);
    run_exec(TMO, 1'b0, 24'd40000);
    press(K_OP, int'(OP_POW));
    chk("chain_ovf_code", 32'(err_code), 32'd3);
    press(K_CLR, 0);

    // Unit error path with negative b
    press(K_DIG, 2); press(K_OP, 1); press(K_DIG, 9); press(K_DIG, 10);
    chk("neg_b", 32'(b), 32'(16'hfff7));
    press(K_EQ, 0);
    run_exec(12, 1'b1, 24'd0);
    press(K_DIG, 5);
    press(K_CLR, 0);

    // Watchdog timeout, then the clear pulse must end
    press(K_DIG, 1); press(K_OP, int'(OP_POW)); press(K_DIG, 1); press(K_EQ, 0);
    run_exec(0, 1'b0, 24'd0);
    tick();
    chk("tmo_clr_once", 32'(unit_clr), 32'd0);
    press(K_CLR, 0);

    // Positive saturation and sign toggle
    press(K_DIG, 3); press(K_DIG, 2); press(K_DIG, 7); press(K_DIG, 6);
    press(K_DIG, 7); press(K_DIG, 8); press(K_DIG, 10); press(K_DIG, 9);
    chk("neg_max", 32'(a), 32'(16'h8001));
    press(K_CLR, 0);
    // Reach -32768; its toggle is dropped
    press(K_DIG, 3); press(K_DIG, 10); press(K_DIG, 2); press(K_DIG, 7);
    press(K_DIG, 6); press(K_DIG, 8); press(K_DIG, 10);
    chk("min_kept", 32'(a), 32'(16'h8000));
    press(K_CLR, 0);

    // CLR during EXEC
    press(K_DIG, 1); press(K_OP, 2); press(K_DIG, 1); press(K_EQ, 0);
    tick(); tick(); tick();
    m_mode = MEX;
    press(K_CLR, 0);
    tick();
    chk("abort_clr_end", 32'(unit_clr), 32'd0);

    // Asynchronous reset mid-EXEC
    press(K_DIG, 1); press(K_OP, 2); press(K_DIG, 1); press(K_EQ, 0);
    tick(); tick();
    #3; RST = 1'b1; #1;
    model_reset();
    check_model("async_rst");
    @(negedge CLK); RST = 1'b0;
    tick();

    // Randomised entry traffic
    press(K_CLR, 0);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 16) press(K_DIG, int'($urandom_range(0, 12)));
      else if (r < 19) press(K_OP, int'($urandom_range(0, 15)));
      else press(K_CLR, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_exec_ctrl.md
Name: calc_exec_ctrl

Overview:
- Top-level sequencer for the calculator.
- Turns keypad events into operand/opcode entry and broadcasts `state`/`opcode` to the arithmetic units (power, etc.).
- Each operation is armed with a one-cycle unit clear, the selected unit's `done` is awaited under a watchdog, then the result or error is latched for display.
- Supports chaining a displayed result as the next operand `a`.

Parameters:
- N, 16, operand width (signed).
- M, 24, result width (signed).
- TMO_CYC, 1024, max cycles in execute before a timeout error.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- key_valid  in  1  one-cycle key strobe
- key_type  in  2  0 DIGIT, 1 OP, 2 EQ, 3 CLR
- key_data  in  4  DIGIT: 0-9 digit, 10 sign toggle, 11-15 ignored; OP: opcode
- unit_done  in  1  selected unit finished
- unit_error  in  1  selected unit error, valid with unit_done
- unit_result  in  M  selected unit result, valid with unit_done
- state  out  3  broadcast state code (define.v)
- opcode  out  4  latched opcode
- a  out  N  operand A
- b  out  N  operand B
- unit_clr  out  1  one-cycle unit clear pulse
- busy  out  1  high in ARM/EXEC
- result  out  M  latched result
- result_valid  out  1  high in SHOW
- err_flag  out  1  high in ERR
- err_code  out  2  0 none, 1 unit error, 2 timeout, 3 chain overflow

Behaviour:
- Reset (async, immediate) values:
  - FSM=IDLE, state=`IDLE, opcode=0, a=b=0, result=0.
  - unit_clr, busy, result_valid, err_flag all 0; err_code=0.
  - Watchdog counter=0.
- FSM states: IDLE, ENTA, ENTB, ARM, EXEC, SHOW, ERR.
- `state` output mapping:
  - ENTA→`ENTA; ENTB→`ENTB; ARM→`ENTB; EXEC→`EXECB; SHOW→`SHOW; ERR→`ERR; IDLE→`IDLE.
  - `state` is registered.
- Key handling:
  - Keys are acted on only when key_valid=1.
  - CLR is honoured in every state: go to IDLE, zero a/b/opcode/result/err_code. If CLR arrives in ARM or EXEC, unit_clr also pulses for the next cycle.
  - All other keys are ignored in ARM and EXEC.
- Digit entry (into a in IDLE/ENTA, into b in ENTB):
  - new = cur*10 + d if cur≥0, else cur*10 − d. Computed at N+5 bits.
  - If new falls outside [−2^(N−1), 2^(N−1)−1], the key is dropped and the operand is unchanged.
  - Sign toggle: cur = −cur; dropped if cur = −2^(N−1).
- IDLE:
  - DIGIT → a=d (toggle on 0), ENTA.
  - OP → opcode latched, b=0, ENTB (a=0).
- ENTA:
  - DIGIT → accumulate into a.
  - OP → opcode=key_data, b=0, ENTB.
  - EQ → ignored.
- ENTB:
  - DIGIT → accumulate into b.
  - OP → replaces opcode.
  - EQ → ARM.
- ARM (exactly 1 cycle): unit_clr=1, busy=1, watchdog cleared → EXEC.
- EXEC:
  - busy=1.
  - unit_done is sampled from the first EXEC cycle onward.
  - On unit_done with unit_error=0: result=unit_result → SHOW.
  - On unit_done with unit_error=1: err_code=1 → ERR.
  - Watchdog counts EXEC cycles. If it reaches TMO_CYC with no done: err_code=2, unit_clr pulse → ERR.
  - If done and timeout coincide, done wins.
- SHOW:
  - result_valid=1.
  - DIGIT → new entry, a=d, ENTA.
  - OP → chain: if result is within N-bit signed range, a=result, opcode latched, b=0, ENTB; otherwise err_code=3 → ERR.
  - EQ → re-execute with b unchanged and a=result (same range check) → ARM.
- ERR:
  - err_flag=1.
  - Only CLR exits.

Decomposition:
- define.v holds the state codes (`IDLE, `ENTA, `ENTB, `EXECB, `SHOW, `ERR) and the opcodes (`POW, ...).
- define.v gains KEY_DIGIT/KEY_OP/KEY_EQ/KEY_CLR, KEY_NEG=10, and ERR_NONE/ERR_UNIT/ERR_TMO/ERR_CHAIN.
- One sub-module, calc_digit_accum: purely combinational. Takes the current operand plus a digit/sign key and returns the next value and an overflow flag. It is instantiated once and shared by a and b, with the FSM selecting the operand.

Test Plan:
- Keys 2,OP(`POW),3,EQ; unit model raises done after 40 cycles with result 8:
  - a=2, b=3, opcode=`POW.
  - unit_clr high exactly 1 cycle.
  - state=`EXECB for 40 cycles.
  - result=8, result_valid=1.
- Keys 2,OP,9,NEG,EQ; model returns done+error:
  - b=−9, then ERR with err_code=1, err_flag=1.
  - CLR → IDLE with all outputs at reset values.
- TMO_CYC=64, model never asserts done:
  - ERR with err_code=2 exactly 64 cycles after EXEC entry.
  - unit_clr pulses once.
- Keys 3,2,7,6,7,8,NEG:
  - a=32767 after the 7; the 8 is dropped; NEG gives a=−32767.
  - A further 9 is dropped.
- Chaining:
  - After result 8: OP(`POW), 2, EQ → a=8, b=2, result 64.
  - Model result 40000, then OP → ERR with err_code=3.
- Abort and reset:
  - CLR during EXEC → unit_clr pulse, IDLE next cycle, busy=0.
  - RST asserted mid-EXEC between clock edges → all outputs at reset values immediately.
